// File: rtl/uart_pkg.sv
// uart_pkg
// Types and constants shared by the f8 UART receiver and transmitter.
//   uart_rx_state_t : receiver frame state (IDLE, START, DATA, STOP)
//   UART_DATA_BITS  : data bits per 8N1 frame
`timescale 1ns/1ps
package uart_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_t;

    localparam int UART_DATA_BITS = 8;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Generic single-clock first-word-fall-through FIFO. The head entry is
// presented on rd_data whenever the FIFO is non-empty and reads as zero
// when it is empty.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (empties the FIFO)
//   push        : write wr_data; accepted when not full, or when full
//                 together with a same-cycle pop
//   wr_data     : data to write
//   pop         : remove head entry; ignored when empty
//   rd_data     : head entry
//   full, empty : occupancy status
//   level       : exact number of stored entries (0..DEPTH)
`timescale 1ns/1ps
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LVL_W'(DEPTH));
    assign level   = level_q;
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    // When full, the slot being written is the head being popped in the
    // same cycle, so the write is safe.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        // Pointer width equals log2(DEPTH), so increments wrap naturally.
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; stale contents are never visible because
    // rd_data is gated by empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data;
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// 8N1 UART receiver for the f8 RX pad. The asynchronous line is brought in
// through a 2-FF synchronizer, sampled at mid-bit, and completed bytes are
// buffered in a small FWFT FIFO drained through a valid/ready port.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   rx          : asynchronous serial input, idles high
//   rd_data     : FIFO head byte (valid while rd_valid)
//   rd_valid    : FIFO non-empty
//   rd_ready    : pop head when rd_valid & rd_ready
//   fifo_level  : FIFO occupancy
//   busy        : receiver is inside a frame
//   frame_err   : sticky, stop bit sampled low
//   overrun     : sticky, byte dropped because the FIFO was full
//   err_clr     : one-cycle pulse clearing both sticky flags
`timescale 1ns/1ps
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 260,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    output logic [UART_DATA_BITS-1:0]     rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          frame_err,
    output logic                          overrun,
    input  logic                          err_clr
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

    uart_rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          bitidx_q, bitidx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      meta_q, rs_q, prev_q;
    logic                      frame_err_q, overrun_q;
    logic                      push, pop, full, empty;
    logic                      set_ferr, set_ovr;

    assign pop       = rd_valid & rd_ready;
    assign rd_valid  = ~empty;
    assign busy      = (state_q != IDLE);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitidx_d = bitidx_q;
        shift_d  = shift_q;
        push     = 1'b0;
        set_ferr = 1'b0;
        set_ovr  = 1'b0;
        case (state_q)
            IDLE: begin
                // Edge, not level: a line stuck low starts nothing.
                if (prev_q && !rs_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    if (!rs_q) begin
                        state_d  = DATA;
                        cnt_d    = '0;
                        bitidx_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d    = '0;
                    shift_d  = {rs_q, shift_q[UART_DATA_BITS-1:1]};
                    bitidx_d = bitidx_q + IDX_W'(1);
                    if (bitidx_q == IDX_LAST) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                // Leave at mid-stop so a following start edge is not missed.
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    if (rs_q) begin
                        if (!full || pop) push    = 1'b1;
                        else              set_ovr = 1'b1;
                    end else begin
                        set_ferr = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q      <= 1'b1;
            rs_q        <= 1'b1;
            prev_q      <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bitidx_q    <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            meta_q      <= rx;
            rs_q        <= meta_q;
            prev_q      <= rs_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bitidx_q    <= bitidx_d;
            shift_q     <= shift_d;
            // A set in the same cycle as err_clr wins.
            frame_err_q <= (frame_err_q & ~err_clr) | set_ferr;
            overrun_q   <= (overrun_q & ~err_clr) | set_ovr;
        end
    end

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data (shift_q),
        .pop     (pop),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level)
    );
endmodule
